operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader_pkg.sv | 16 +
 rtl/operand_loader_btn_debouncer.sv | 58 +++++
 rtl/operand_loader.sv | 95 +++++++++
 tb/tb_operand_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: FSM state codes, widths and
// the default button debounce length.
package operand_loader_pkg;

    localparam int STATE_W             = 2;
    localparam int OPERAND_W           = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;

    typedef enum logic [STATE_W-1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        RUN    = 2'd2,
        SHOW   = 2'd3
    } state_e;

endpackage

// File: rtl/operand_loader_btn_debouncer.sv
// Pushbutton front end: 2-flop synchronizer, stability counter and a
// registered rising-edge detector producing a one-cycle press pulse.
module btn_debouncer
    import operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             stable_dly_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any cycle where the synced level agrees with the stable level restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= stable_q & ~stable_dly_q;
            cnt_q        <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/operand_loader.sv
// Loads two 8-bit operands from switches on successive button presses,
// kicks the multiplier and waits for its completion.
//
// state  | meaning
// LOAD_A | waiting for press to latch op_a
// LOAD_B | waiting for press to latch op_b and start the multiplier
// RUN    | multiplication outstanding, presses discarded
// SHOW   | result available, press returns to LOAD_A
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn,
    input  logic [OPERAND_W-1:0] sw,
    input  logic                 mul_done,
    output logic [OPERAND_W-1:0] op_a,
    output logic [OPERAND_W-1:0] op_b,
    output logic                 start,
    output logic                 busy,
    output logic [STATE_W-1:0]   phase
);

    state_e               state_q, state_d;
    logic [OPERAND_W-1:0] op_a_q, op_a_d;
    logic [OPERAND_W-1:0] op_b_q, op_b_d;
    logic                 start_q, start_d;
    logic                 press;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debouncer (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .press(press)
    );

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        start_d = 1'b0;
        case (state_q)
            LOAD_A: begin
                if (press) begin
                    op_a_d  = sw;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press) begin
                    op_b_d  = sw;
                    start_d = 1'b1;
                    state_d = RUN;
                end
            end
            // mul_done takes priority; a coincident press is simply dropped.
            RUN: begin
                if (mul_done) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (press) begin
                    state_d = LOAD_A;
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_A;
            op_a_q  <= '0;
            op_b_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            start_q <= start_d;
        end
    end

    assign op_a  = op_a_q;
    assign op_b  = op_b_q;
    assign start = start_q;
    assign busy  = (state_q == RUN);
    assign phase = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: directed scenarios plus random
// button/switch/mul_done traffic against a behavioural reference model.
module tb_operand_loader;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       mul_done = 1'b0;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       start;
    logic       busy;
    logic [1:0] phase;

    int n_checks = 0;
    int n_fail   = 0;

    operand_loader #(.DEBOUNCE_CYCLES(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .sw      (sw),
        .mul_done(mul_done),
        .op_a    (op_a),
        .op_b    (op_b),
        .start   (start),
        .busy    (busy),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last N btn samples all
    // differ from the accepted level; a 0->1 acceptance becomes a press the
    // FSM sees four edges after the deciding sample.
    bit         hist[$];
    bit         lvl;
    bit         pipe[3];
    bit         mp_vis;
    int         m_state;
    logic [7:0] m_a, m_b;
    bit         m_start;

    function automatic void model_reset();
        hist.delete();
        lvl     = 0;
        pipe[0] = 0; pipe[1] = 0; pipe[2] = 0;
        mp_vis  = 0;
        m_state = 0;
        m_a     = 8'h00;
        m_b     = 8'h00;
        m_start = 0;
    endfunction

    function automatic void model_step(bit b, logic [7:0] s, bit d);
        bit fp = mp_vis;
        bit r  = 0;
        bit all_diff;
        m_start = 0;
        case (m_state)
            0: if (fp) begin m_a = s; m_state = 1; end
            1: if (fp) begin m_b = s; m_state = 2; m_start = 1; end
            2: if (d) m_state = 3;
            default: if (fp) m_state = 0;
        endcase
        hist.push_back(b);
        if (hist.size() > N) void'(hist.pop_front());
        if (hist.size() == N) begin
            all_diff = 1;
            foreach (hist[i]) if (hist[i] == lvl) all_diff = 0;
            if (all_diff) begin
                lvl = !lvl;
                r   = lvl;
            end
        end
        mp_vis  = pipe[2];
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input bit b, input logic [7:0] s, input bit d);
        @(negedge clk);
        btn = b; sw = s; mul_done = d;
        @(posedge clk);
        model_step(b, s, d);
        #1;
        check_eq("phase", 32'(phase), m_state);
        check_eq("op_a", 32'(op_a), 32'(m_a));
        check_eq("op_b", 32'(op_b), 32'(m_b));
        check_eq("start", 32'(start), 32'(m_start));
        check_eq("busy", 32'(busy), (m_state == 2) ? 1 : 0);
    endtask

    task automatic do_reset(input bit b);
        @(negedge clk);
        btn = b; mul_done = 1'b0; rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_phase", 32'(phase), 0);
        check_eq("rst_op_a", 32'(op_a), 0);
        check_eq("rst_op_b", 32'(op_b), 0);
        check_eq("rst_start", 32'(start), 0);
        check_eq("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic press_seq(input logic [7:0] s, input int hi, input int lo, input int tgt,
                             output int lat, output int starts);
        lat = -1; starts = 0;
        for (int i = 0; i < hi + lo; i++) begin
            cyc(i < hi, s, 1'b0);
            if (start) starts++;
            if (lat < 0 && 32'(phase) == tgt) lat = i;
        end
    endtask

    int lat, starts;
    bit rb;
    int run_left;

    initial begin
        model_reset();
        do_reset(1'b0);

        // mul_done ignored in LOAD_A
        cyc(0, 8'h00, 1); cyc(0, 8'h00, 0);
        check_eq("done_in_load_a_phase", 32'(phase), 0);
        check_eq("done_in_load_a_busy", 32'(busy), 0);

        // clean operand load
        press_seq(8'h0C, 12, 8, 1, lat, starts);
        check_eq("press_latency", lat, N + 3);
        check_eq("load_a_value", 32'(op_a), 32'h0C);
        cyc(0, 8'h00, 1); cyc(0, 8'h00, 0);
        check_eq("done_in_load_b_phase", 32'(phase), 1);
        check_eq("done_in_load_b_busy", 32'(busy), 0);
        press_seq(8'h0B, 12, 8, 2, lat, starts);
        check_eq("start_pulses", starts, 1);
        check_eq("load_b_value", 32'(op_b), 32'h0B);
        check_eq("run_busy", 32'(busy), 1);
        cyc(0, 8'h00, 1); cyc(0, 8'h00, 0);
        check_eq("show_phase", 32'(phase), 3);
        check_eq("show_busy", 32'(busy), 0);
        press_seq(8'hFF, 12, 8, 0, lat, starts);
        check_eq("show_to_load_a_op_a", 32'(op_a), 32'h0C);

        // bounce: 2-cycle toggles, then a steady high
        for (int i = 0; i < 8; i++) cyc((i % 4) < 2, 8'h5A, 1'b0);
        check_eq("bounce_no_press", 32'(phase), 0);
        press_seq(8'h5A, 14, 8, 1, lat, starts);
        check_eq("bounce_latency", lat, N + 3);
        check_eq("bounce_op_a", 32'(op_a), 32'h5A);

        // press during RUN is discarded
        press_seq(8'h33, 12, 8, 2, lat, starts);
        press_seq(8'h77, 12, 8, 3, lat, starts);
        check_eq("run_press_no_exit", lat, -1);
        check_eq("run_press_no_start", starts, 0);
        cyc(0, 8'h00, 1); cyc(0, 8'h00, 0);
        check_eq("run_press_phase", 32'(phase), 3);
        check_eq("run_press_op_a", 32'(op_a), 32'h5A);
        check_eq("run_press_op_b", 32'(op_b), 32'h33);

        // press coinciding with mul_done in RUN
        press_seq(8'h00, 12, 8, 0, lat, starts);
        press_seq(8'h11, 12, 8, 1, lat, starts);
        press_seq(8'h22, 12, 8, 2, lat, starts);
        for (int i = 0; i < 20; i++) cyc(i < 12, 8'h99, i == N + 3);
        check_eq("coincide_phase", 32'(phase), 3);

        // reset mid-RUN, late mul_done ignored
        press_seq(8'h00, 12, 8, 0, lat, starts);
        press_seq(8'h44, 12, 8, 1, lat, starts);
        press_seq(8'h55, 12, 8, 2, lat, starts);
        do_reset(1'b0);
        cyc(0, 8'h00, 1); cyc(0, 8'h00, 0);
        check_eq("after_rst_done_phase", 32'(phase), 0);
        check_eq("after_rst_done_busy", 32'(busy), 0);

        // btn held high across reset release
        do_reset(1'b1);
        press_seq(8'h66, 12, 8, 1, lat, starts);
        check_eq("rst_release_latency", lat, N + 3);
        check_eq("rst_release_op_a", 32'(op_a), 32'h66);

        // random traffic
        rb = 0; run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                rb = ~rb;
                run_left = $urandom_range(1, 9);
            end
            run_left--;
            cyc(rb, 8'($urandom), $urandom_range(0, 7) == 0);
            if (i == 1500) do_reset(rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
